// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - operation encodings (MULT, MULTU, DIV, DIVU)
//   - FSM state encoding (IDLE, CALC, FIX)
//   - default operand width and iteration counter width
//   - small decode helpers used by the top and the sign-fix stage
package muldiv_unit_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 5;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Bit 1 of the opcode selects divide, bit 0 selects unsigned.
    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Bus between the EX stage / hazard unit and the multiply/divide unit.
//   master : issues start/op/srcA/srcB and MTHI/MTLO writes, observes busy/done/hi/lo
//   slave  : the muldiv_unit itself
interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    op_e              op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             hiWr;
    logic             loWr;
    logic [WIDTH-1:0] wrData;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srcA, srcB, hiWr, loWr, wrData,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB, hiWr, loWr, wrData,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_unit_signfix.sv
// Combinational sign handling around the unsigned iterative datapath.
//   Inputs side : op_i, src_a_i, src_b_i -> mag_a_o/mag_b_o (magnitudes for
//                 signed ops, raw values for unsigned ops), neg_q_o (sign of
//                 product/quotient) and neg_r_o (sign of remainder).
//   Result side : res_op_i, res_neg_q_i, res_neg_r_i, res_div0_i, acc_i
//                 (raw unsigned product, or remainder:quotient) -> hi_o/lo_o.
module muldiv_signfix
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  op_e                op_i,
    input  logic [WIDTH-1:0]   src_a_i,
    input  logic [WIDTH-1:0]   src_b_i,
    output logic [WIDTH-1:0]   mag_a_o,
    output logic [WIDTH-1:0]   mag_b_o,
    output logic               neg_q_o,
    output logic               neg_r_o,
    input  op_e                res_op_i,
    input  logic               res_neg_q_i,
    input  logic               res_neg_r_i,
    input  logic               res_div0_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    logic               sign_a;
    logic               sign_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_raw;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign sign_a  = op_is_signed(op_i) & src_a_i[WIDTH-1];
    assign sign_b  = op_is_signed(op_i) & src_b_i[WIDTH-1];
    // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
    assign mag_a_o = sign_a ? (~src_a_i + 1'b1) : src_a_i;
    assign mag_b_o = sign_b ? (~src_b_i + 1'b1) : src_b_i;
    assign neg_q_o = sign_a ^ sign_b;
    assign neg_r_o = sign_a;

    assign quot_raw = acc_i[WIDTH-1:0];
    assign rem_raw  = acc_i[2*WIDTH-1:WIDTH];
    assign prod_fix = res_neg_q_i ? (~acc_i + 1'b1) : acc_i;
    // Divide by zero: quotient is all ones regardless of sign. The remainder
    // magnitude equals |srcA|, so re-applying srcA's sign restores srcA exactly.
    assign quot_fix = res_div0_i  ? '1 :
                      res_neg_q_i ? (~quot_raw + 1'b1) : quot_raw;
    assign rem_fix  = res_neg_r_i ? (~rem_raw + 1'b1) : rem_raw;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        hi_o = prod_fix[2*WIDTH-1:WIDTH];
        lo_o = prod_fix[WIDTH-1:0];
        if (op_is_div(res_op_i)) begin
            hi_o = rem_fix;
            lo_o = quot_fix;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : muldiv_unit_if.slave -- start/op/srcA/srcB launch an operation,
//                hiWr/loWr/wrData implement MTHI/MTLO, busy/done/hi/lo report.
// One shift-add (multiply) or restoring (divide) step per cycle on unsigned
// magnitudes, then a single FIX cycle applies signs and loads HI/LO.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    op_e                op_q;
    logic [WIDTH-1:0]   mag_a_q;
    logic [WIDTH-1:0]   mag_b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               neg_q_q;
    logic               neg_r_q;
    logic               div0_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] acc_step;

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .op_i        (bus.op),
        .src_a_i     (bus.srcA),
        .src_b_i     (bus.srcB),
        .mag_a_o     (mag_a),
        .mag_b_o     (mag_b),
        .neg_q_o     (neg_q),
        .neg_r_o     (neg_r),
        .res_op_i    (op_q),
        .res_neg_q_i (neg_q_q),
        .res_neg_r_i (neg_r_q),
        .res_div0_i  (div0_q),
        .acc_i       (acc_q),
        .hi_o        (fix_hi),
        .lo_o        (fix_lo)
    );

    // Divide: remainder lives in acc[2W-1:W], quotient shifts into acc[W-1:0];
    // dividend bits enter from the top of mag_a_q. The extra bit of rem_diff
    // is the borrow of the trial subtraction.
    assign rem_shift = {acc_q[2*WIDTH-1:WIDTH], mag_a_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, mag_b_q};

    always_comb begin
        acc_step = acc_q;
        if (op_is_div(op_q)) begin
            if (!rem_diff[WIDTH]) begin
                acc_step = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            // MSB-first shift-add: multiplier bits are consumed from the top.
            acc_step = {acc_q[2*WIDTH-2:0], 1'b0}
                     + (mag_b_q[WIDTH-1] ? {{WIDTH{1'b0}}, mag_a_q} : '0);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process ordering.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start seen outside IDLE is ignored.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (cnt_q == LAST_CNT) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        bus.busy = (state_q != IDLE);
    end

    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Datapath and architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            mag_a_q <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == FIX);
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        mag_a_q <= mag_a;
                        mag_b_q <= mag_b;
                        neg_q_q <= neg_q;
                        neg_r_q <= neg_r;
                        div0_q  <= (bus.srcB == '0);
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else begin
                        if (bus.hiWr) hi_q <= bus.wrData;
                        if (bus.loWr) lo_q <= bus.wrData;
                    end
                end
                CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (op_is_div(op_q)) begin
                        mag_a_q <= {mag_a_q[WIDTH-2:0], 1'b0};
                    end else begin
                        mag_b_q <= {mag_b_q[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    always #5 clk = ~clk;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // The hazard unit must never issue start while busy.
    always @(posedge clk) begin
        if (rst_n && bus.start && bus.busy) begin
            checks++;
            errors++;
            $display("FAIL start_while_busy: start=1 observed with busy=1 at %0t", $time);
        end
    end

    task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                          input bit wr_with_start, input bit wr_in_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input string name);
        int busy_bad = 0;
        int view_bad = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.srcA  = a;
        bus.srcB  = b;
        if (wr_with_start) begin
            bus.hiWr   = 1'b1;
            bus.loWr   = 1'b1;
            bus.wrData = 32'h1111_1111;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.hiWr  = 1'b0;
        bus.loWr  = 1'b0;
        bus.srcA  = 32'h0;
        bus.srcB  = 32'h0;
        checks++;
        if (bus.busy !== 1'b1 || bus.hi !== model_hi || bus.lo !== model_lo) begin
            errors++;
            $display("FAIL %s_launch: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h",
                     name, bus.busy, bus.hi, bus.lo, model_hi, model_lo);
        end
        for (int i = 1; i <= 32; i++) begin
            if (wr_in_busy && i == 5) begin
                bus.hiWr   = 1'b1;
                bus.loWr   = 1'b1;
                bus.wrData = 32'h2222_2222;
            end
            @(posedge clk); #1;
            bus.hiWr = 1'b0;
            bus.loWr = 1'b0;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_bad++;
            if (bus.hi !== model_hi || bus.lo !== model_lo) view_bad++;
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s_busy_window: %0d of 32 cycles wrong, want busy=1 done=0", name, busy_bad);
        end
        checks++;
        if (view_bad != 0) begin
            errors++;
            $display("FAIL %s_hilo_hold: %0d of 32 cycles changed hi/lo, want hi=%h lo=%h",
                     name, view_bad, model_hi, model_lo);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b busy=%b, want done=1 busy=0", name, bus.done, bus.busy);
        end
        checks++;
        if (bus.hi !== exp_hi) begin
            errors++;
            $display("FAIL %s_hi: got %h want %h", name, bus.hi, exp_hi);
        end
        checks++;
        if (bus.lo !== exp_lo) begin
            errors++;
            $display("FAIL %s_lo: got %h want %h", name, bus.lo, exp_lo);
        end
        model_hi = exp_hi;
        model_lo = exp_lo;
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b one cycle later, want 0", name, bus.done);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = OP_MULT;
        bus.srcA   = 32'h0;
        bus.srcB   = 32'h0;
        bus.hiWr   = 1'b0;
        bus.loWr   = 1'b0;
        bus.wrData = 32'h0;
        model_hi   = 32'h0;
        model_lo   = 32'h0;
        #12;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all zero",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_release: busy=%b hi=%h lo=%h, want 0/0/0", bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_mult();
        run_op(OP_MULT, 32'd7, 32'd6, 1'b0, 1'b0, 32'h0, 32'd42, "mult_7x6");
    endtask

    task automatic test_mult_signs();
        run_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,
               32'h0000_0000, 32'h0000_0001, "mult_m1xm1");
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0,
               32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5");
    endtask

    task automatic test_div();
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        run_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0,
               32'h0000_0001, 32'hFFFF_FFFD, "div_7_m2");
    endtask

    task automatic test_div_boundaries();
        run_op(OP_DIVU, 32'h64, 32'h0, 1'b0, 1'b0,
               32'h0000_0064, 32'hFFFF_FFFF, "divu_by_zero");
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0,
               32'h0000_0000, 32'h8000_0000, "div_overflow");
    endtask

    task automatic test_mt_writes();
        @(negedge clk);
        bus.hiWr   = 1'b1;
        bus.wrData = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.hiWr = 1'b0;
        model_hi = 32'hDEAD_BEEF;
        checks++;
        if (bus.hi !== model_hi || bus.lo !== model_lo) begin
            errors++;
            $display("FAIL mthi: hi=%h lo=%h, want hi=%h lo=%h", bus.hi, bus.lo, model_hi, model_lo);
        end
        @(negedge clk);
        bus.hiWr   = 1'b1;
        bus.loWr   = 1'b1;
        bus.wrData = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        bus.hiWr = 1'b0;
        bus.loWr = 1'b0;
        model_hi = 32'hA5A5_A5A5;
        model_lo = 32'hA5A5_A5A5;
        checks++;
        if (bus.hi !== model_hi || bus.lo !== model_lo) begin
            errors++;
            $display("FAIL mthi_mtlo_both: hi=%h lo=%h, want %h", bus.hi, bus.lo, model_hi);
        end
    endtask

    task automatic test_write_drop();
        run_op(OP_DIVU,  32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 32'd14, "divu_wr_busy");
        run_op(OP_MULTU, 32'd2,   32'd3, 1'b1, 1'b0, 32'd0, 32'd6,  "multu_wr_start");
    endtask

    task automatic test_abort();
        int done_seen = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.srcA  = 32'd3;
        bus.srcB  = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_hi = 32'h0;
        model_lo = 32'h0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: busy=%b done=%b, want 0/0", bus.busy, bus.done);
        end
        checks++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++;
            $display("FAIL abort_hilo: hi=%h lo=%h, want 0/0", bus.hi, bus.lo);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d cycles with done/busy set after abort, want 0", done_seen);
        end
        run_op(OP_MULT, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0, 32'd15, "mult_after_abort");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_mult_signs();
        test_div();
        test_div_boundaries();
        test_mt_writes();
        test_write_drop();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes the two register read buses for MULT/MULTU/DIV/DIVU.
- Holds the architectural HI/LO registers read by MFHI/MFLO and written by MTHI/MTLO.
- Reports busy so the hazard unit can stall any HI/LO access while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; 2**CNT_W must equal WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to launch the operation in op.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srcA  input  WIDTH  multiplicand or dividend (from BusA).
- srcB  input  WIDTH  multiplier or divisor (from BusB).
- hiWr  input  1  MTHI write strobe.
- loWr  input  1  MTLO write strobe.
- wrData  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, all internal operand/partial registers=0. Reset mid-operation aborts it; no result is written.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge N:
  - Latch op.
  - Latch |srcA| and |srcB| for signed ops (raw values for unsigned ops).
  - Record result signs: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
  - Clear the partial accumulator (2*WIDTH bits) and the counter.
  - busy=1; go to CALC.
- CALC:
  - Multiply: one shift-add step per edge on the unsigned magnitudes.
  - Divide: one restoring step per edge (shift remainder:quotient left, trial subtract, set quotient bit).
  - Counter increments each edge; after the step with counter==WIDTH-1, go to FIX.
  - Exactly WIDTH CALC edges.
- FIX (one edge):
  - Apply sign correction (two's complement of product, quotient or remainder as recorded).
  - Load hi/lo: MULT/MULTU hi=product[63:32], lo=product[31:0]; DIV/DIVU lo=quotient, hi=remainder.
  - done=1 for the following cycle only; busy=0; return to IDLE.
- Latency: start sampled at edge N; busy high after edges N+1..N+32; hi/lo valid and done=1 after edge N+33; busy=0 after edge N+33. Total 33 cycles.
- Divide by zero (srcB=0): not trapped; same latency; result lo=32'hFFFFFFFF, hi=srcA (original, unmodified).
- Overflow case DIV 0x80000000 / -1: lo=0x80000000, hi=0; no exception.
- start while busy: ignored, no effect. The hazard unit must not issue it; the bench asserts it never happens.
- hiWr/loWr:
  - Take effect only in IDLE with start=0; hi or lo is loaded with wrData on that edge.
  - Both strobes set together write the same wrData to both registers.
  - Dropped while busy or when start=1 on the same edge (start has priority).
- hi/lo hold their value at all other times; MFHI/MFLO read them combinationally.
- No partial results are visible on hi/lo during CALC.

Decomposition:
- Shared package holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state enum: IDLE, CALC, FIX.
  - WIDTH default.
- One natural sub-module: muldiv_signfix. Combinational; does input magnitude conversion and final two's-complement correction, so the iterative datapath stays unsigned.
- Iteration datapath and FSM remain in muldiv_unit.

Test Plan:
- Reset then MULT srcA=7, srcB=6 at edge N → busy=1 edges N+1..N+32; done pulse after edge N+33; hi=0, lo=42.
- MULT 0xFFFFFFFF×0xFFFFFFFF → hi=0, lo=1. MULTU same operands → hi=0xFFFFFFFE, lo=0x00000001.
- DIV srcA=0xFFFFFFF9 (-7), srcB=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 → lo=14, hi=2.
- DIVU srcA=0x64, srcB=0 → after 33 cycles lo=0xFFFFFFFF, hi=0x64. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI wrData=0xDEADBEEF in IDLE → hi=0xDEADBEEF next cycle. hiWr/loWr with start=1 → dropped. hiWr during busy → dropped; final hi is the operation result.
- Start MULT 3×5, pull rst_n low at cycle N+10 (asynchronously, mid-cycle) → busy=0, hi=lo=0 immediately. After release, a new MULT 3×5 gives lo=15 with full 33-cycle latency; done never pulses for the aborted operation.
